wb_dsize_32to8: RTL

WB_DSIZE_32TO8 -- requirements
Module: wb_dsize_32to8

---
 rtl/wb_dsize_32to8.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/wb_dsize_32to8.sv
`default_nettype none
// wb_dsize_32to8 -- bridges a 32-bit Wishbone master onto an 8-bit Wishbone slave,
// issuing one byte beat per selected lane in ascending order.  Rev 1.0
module wb_dsize_32to8 #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_adr_i,
  input  logic [31:0]           s_dat_i,
  input  logic                  s_we_i,
  input  logic [3:0]            s_sel_i,
  input  logic                  s_cyc_i,
  input  logic                  s_stb_i,
  output logic [31:0]           s_dat_o,
  output logic                  s_ack_o,
  output logic                  s_err_o,
  output logic                  s_rty_o,
  output logic [ADDR_WIDTH-1:0] m_adr_o,
  output logic [7:0]            m_dat_o,
  output logic                  m_we_o,
  output logic                  m_sel_o,
  output logic                  m_cyc_o,
  output logic                  m_stb_o,
  input  logic [7:0]            m_dat_i,
  input  logic                  m_ack_i,
  input  logic                  m_err_i,
  input  logic                  m_rty_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-3:0] adr_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           wdat_q;
  logic [31:0]           rbuf_q;
  logic [1:0]            lane_q;

  logic [1:0]            first_lane;
  logic [1:0]            next_lane;
  logic [3:0]            later_mask;
  logic                  more_lanes;
  logic                  beat_end;
  logic [31:0]           rd_merged;

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    if (m[0]) return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    return 2'd3;
  endfunction

  // later_mask keeps only selected lanes strictly above the current one.
  always_comb begin
    first_lane = low_lane(s_sel_i);
    later_mask = sel_q & (4'b1110 << lane_q);
    next_lane  = low_lane(later_mask);
    more_lanes = |later_mask;
    beat_end   = !s_cyc_i || m_err_i || m_rty_i || (m_ack_i && !more_lanes);
    rd_merged  = rbuf_q;
    rd_merged[{lane_q, 3'b000} +: 8] = m_dat_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      wdat_q  <= '0;
      rbuf_q  <= '0;
      lane_q  <= 2'd0;
      s_dat_o <= '0;
      s_ack_o <= 1'b0;
      s_err_o <= 1'b0;
      s_rty_o <= 1'b0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      m_we_o  <= 1'b0;
      m_sel_o <= 1'b0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_cyc_i && s_stb_i) begin
            adr_q  <= s_adr_i[ADDR_WIDTH-1:2];
            we_q   <= s_we_i;
            sel_q  <= s_sel_i;
            wdat_q <= s_dat_i;
            rbuf_q <= '0;
            if (s_sel_i == 4'b0000) begin
              state_q <= RESP;
              s_ack_o <= 1'b1;
              s_dat_o <= '0;
            end else begin
              state_q <= BEAT;
              lane_q  <= first_lane;
              m_adr_o <= {s_adr_i[ADDR_WIDTH-1:2], first_lane};
              m_dat_o <= s_dat_i[{first_lane, 3'b000} +: 8];
              m_we_o  <= s_we_i;
              m_sel_o <= 1'b1;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
            end
          end
        end

        BEAT: begin
          if (beat_end) begin
            m_adr_o <= '0;
            m_dat_o <= '0;
            m_we_o  <= 1'b0;
            m_sel_o <= 1'b0;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
          end
          // An abandoned cycle wins over any response arriving with it.
          if (!s_cyc_i) begin
            state_q <= IDLE;
          end else if (m_err_i) begin
            state_q <= RESP;
            s_err_o <= 1'b1;
          end else if (m_rty_i) begin
            state_q <= RESP;
            s_rty_o <= 1'b1;
          end else if (m_ack_i) begin
            if (!we_q) rbuf_q <= rd_merged;
            if (more_lanes) begin
              lane_q  <= next_lane;
              m_adr_o <= {adr_q, next_lane};
              m_dat_o <= wdat_q[{next_lane, 3'b000} +: 8];
            end else begin
              state_q <= RESP;
              s_ack_o <= 1'b1;
              s_dat_o <= we_q ? 32'h0 : rd_merged;
            end
          end
        end

        RESP: begin
          s_ack_o <= 1'b0;
          s_err_o <= 1'b0;
          s_rty_o <= 1'b0;
          s_dat_o <= '0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
